// File: rtl/div.sv
// 32-bit iterative divider, signed (DIV) and unsigned (DIVU).
// result_o = {remainder, quotient}. One restoring step per cycle,
// 32 steps, then sign fix-up. Divide-by-zero yields an all-zero result.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] partial;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes; 0x80000000 maps onto itself and is read as 2^31.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i && opdata1_i[31]) op1_abs = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31]) op2_abs = ~opdata2_i + 32'd1;
  end

  // One restoring step: quo doubles as the dividend shift register, so the
  // next dividend bit enters the remainder from quo[31] while the new
  // quotient bit enters quo from the bottom.
  always_comb begin
    partial = {rem, quo[31]};
    diff    = partial - {1'b0, dvsr};
    rem_nxt = diff[32] ? partial[31:0] : diff[31:0];
    quo_nxt = {quo[30:0], ~diff[32]};
  end

  // Sign fix-up applied when the 32 steps are done.
  always_comb begin
    q_fix = neg_q ? (~quo + 32'd1) : quo;
    r_fix = neg_r ? (~rem + 32'd1) : rem;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              cnt   <= '0;
              rem   <= '0;
              quo   <= op1_abs;
              dvsr  <= op2_abs;
              neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_r <= signed_div_i & opdata1_i[31];
            end
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != 6'd32) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          state    <= FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: arithmetic reference model with a
// transaction-level latency model, compared every cycle, plus directed
// vectors with hand-computed results.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference quotient/remainder from plain arithmetic.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    if (b == 32'd0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Transaction-level model: a started request becomes ready a fixed
  // number of edges later unless annulled (only a real division is annullable).
  logic        m_busy, m_ready, m_annulable;
  logic [63:0] m_res, m_pending;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_res   <= '0;
    end else if (m_ready) begin
      if (!start_i) begin
        m_ready <= 1'b0;
        m_res   <= '0;
      end
    end else if (m_busy) begin
      if (m_annulable && annul_i) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_res   <= m_pending;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start_i && !annul_i) begin
      m_busy      <= 1'b1;
      m_left      <= (opdata2_i == 32'd0) ? 1 : 33;
      m_annulable <= (opdata2_i != 32'd0);
      m_pending   <= ref_div(signed_div_i, opdata1_i, opdata2_i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("cyc_result", result_o, m_res);
    end
  end

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit scramble);
    int n;
    bit seen;
    int lat;
    lat = (b == 32'd0) ? 1 : 33;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready_o) seen = 1;
      else if (scramble && n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
    end
    if (!seen) begin
      chk("ready_timeout", 64'd0, 64'd1);
    end else begin
      chk("latency", 64'(n - 1), 64'(lat));
      chk("result", result_o, exp);
    end
    // Held while start stays high; annul must be ignored here.
    annul_i = 1'b1;
    @(posedge clk); #1;
    chk("end_hold_ready", {63'd0, ready_o}, 64'd1);
    chk("end_hold_result", result_o, exp);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", {63'd0, ready_o}, 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    vecs[0]  = '{0, 32'd100,        32'd7,        64'h00000002_0000000E};
    vecs[1]  = '{1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{0, 32'd5,          32'd0,        64'h00000000_00000000};
    vecs[3]  = '{0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
    vecs[4]  = '{1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[5]  = '{0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000};
    vecs[6]  = '{1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[7]  = '{1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
    vecs[8]  = '{0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC};
    vecs[9]  = '{1, 32'd0,          32'd5,        64'h00000000_00000000};
    vecs[10] = '{1, 32'hFFFFFFFB,   32'd0,        64'h00000000_00000000};
    vecs[11] = '{0, 32'h12345678,   32'd1000,     64'h00000380_0004A90B};

    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;

    // Pin the reference model to the hand-computed values.
    foreach (vecs[i]) chk("model", ref_div(vecs[i].s, vecs[i].a, vecs[i].b), vecs[i].exp);

    @(posedge clk); #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors; odd entries scramble operands after the start edge.
    foreach (vecs[i]) run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, bit'(i % 2));

    // Start with annul high in FREE: nothing may begin.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    repeat (3) @(posedge clk);
    #1 chk("free_annul_ready", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;

    // Annul is ignored in BYZERO.
    signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    chk("byzero_annul_ready", {63'd0, ready_o}, 64'd1);
    chk("byzero_annul_result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    chk("byzero_drop_ready", {63'd0, ready_o}, 64'd0);

    // Annul at E10 aborts; ready must stay low through E40.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);                 // E0
    repeat (9) @(posedge clk);      // E1..E9
    #1 annul_i = 1'b1;
    @(posedge clk); #1;             // E10
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    chk("annul_result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1;
    end
    chk("annul_quiet", {63'd0, seen}, 64'd0);
    run_div(0, 32'd9, 32'd3, 64'h00000000_00000003, 0);

    // Reset at E20 mid-division.
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFC18; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);                 // E0
    repeat (19) @(posedge clk);     // E1..E19
    #1 rst = 1'b1;
    @(posedge clk); #1;             // E20
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1;
    end
    chk("midrst_quiet", {63'd0, seen}, 64'd0);
    run_div(1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1);

    @(posedge clk); #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
